// File: rtl/clic_pkg.sv
// clic_pkg: shared types for the CLIC interrupt sender.
package clic_pkg;

    localparam int unsigned ClicNumSrc   = 256;
    localparam int unsigned ClicIdWidth  = $clog2(ClicNumSrc);
    localparam int unsigned ClicLvlWidth = 8;

    typedef struct packed {
        logic                    valid;
        logic [ClicIdWidth-1:0]  id;
        logic [ClicLvlWidth-1:0] level;
        logic [1:0]              priv;
        logic                    shv;
    } clic_sel_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_OFFER,
        TX_KILL
    } clic_tx_state_e;

endpackage

// File: rtl/clic_arb_tree.sv
// clic_arb_tree: combinational binary max-tree over (level, id); ties go to the higher id.
module clic_arb_tree #(
    parameter int unsigned NumSrc   = 256,
    parameter int unsigned IdWidth  = $clog2(NumSrc),
    parameter int unsigned LvlWidth = 8
) (
    input  logic [NumSrc-1:0]   valid_i,
    input  logic [LvlWidth-1:0] level_i [NumSrc],
    output logic                valid_o,
    output logic [IdWidth-1:0]  id_o,
    output logic [LvlWidth-1:0] level_o
);

    localparam int unsigned Leaves = 1 << IdWidth;

    // Heap layout: node k has children 2k+1 (lower ids) and 2k+2 (higher ids).
    logic                n_valid [2*Leaves-1];
    logic [IdWidth-1:0]  n_id    [2*Leaves-1];
    logic [LvlWidth-1:0] n_lvl   [2*Leaves-1];
    logic                take_r  [Leaves-1];

    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            n_valid[Leaves-1+i] = valid_i[i];
            n_id[Leaves-1+i]    = IdWidth'(i);
            n_lvl[Leaves-1+i]   = level_i[i];
        end
        for (int i = NumSrc; i < Leaves; i++) begin
            n_valid[Leaves-1+i] = 1'b0;
            n_id[Leaves-1+i]    = IdWidth'(i);
            n_lvl[Leaves-1+i]   = '0;
        end
        for (int k = Leaves - 2; k >= 0; k--) begin
            take_r[k]  = n_valid[2*k+2] && (!n_valid[2*k+1] || n_lvl[2*k+2] >= n_lvl[2*k+1]);
            n_valid[k] = n_valid[2*k+1] | n_valid[2*k+2];
            n_id[k]    = take_r[k] ? n_id[2*k+2] : n_id[2*k+1];
            n_lvl[k]   = take_r[k] ? n_lvl[2*k+2] : n_lvl[2*k+1];
        end
        valid_o = n_valid[0];
        id_o    = n_id[0];
        level_o = n_lvl[0];
    end

endmodule

// File: rtl/clic_irq_sender.sv
// clic_irq_sender: arbitrates eligible CLIC sources and offers the winner to the core
// over a valid/ready handshake with kill retraction and a claim pulse.
module clic_irq_sender
    import clic_pkg::*;
#(
    parameter int unsigned NumSrc   = ClicNumSrc,
    parameter int unsigned IdWidth  = $clog2(NumSrc),
    parameter int unsigned LvlWidth = ClicLvlWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumSrc-1:0]   pending_i,
    input  logic [NumSrc-1:0]   enable_i,
    input  logic [LvlWidth-1:0] level_i [NumSrc],
    input  logic [1:0]          priv_i  [NumSrc],
    input  logic [NumSrc-1:0]   shv_i,
    input  logic [LvlWidth-1:0] thresh_i,
    output logic                irq_valid_o,
    input  logic                irq_ready_i,
    output logic [IdWidth-1:0]  irq_id_o,
    output logic [LvlWidth-1:0] irq_level_o,
    output logic [1:0]          irq_priv_o,
    output logic                irq_shv_o,
    output logic                irq_kill_req_o,
    input  logic                irq_kill_ack_i,
    output logic                claim_o,
    output logic [IdWidth-1:0]  claim_id_o
);

    logic [NumSrc-1:0]   elig;
    logic                win_valid;
    logic [IdWidth-1:0]  win_id;
    logic [LvlWidth-1:0] win_lvl;
    clic_sel_t           sel_d, sel_q;
    clic_tx_state_e      state_d, state_q;
    logic                valid_d, valid_q, kill_d, kill_q, claim_d, claim_q, shv_d, shv_q;
    logic [IdWidth-1:0]  id_d, id_q, claim_id_d, claim_id_q;
    logic [LvlWidth-1:0] lvl_d, lvl_q;
    logic [1:0]          priv_d, priv_q;

    always_comb begin
        for (int i = 0; i < NumSrc; i++) elig[i] = pending_i[i] & enable_i[i] & (level_i[i] > thresh_i);
    end

    clic_arb_tree #(.NumSrc(NumSrc), .IdWidth(IdWidth), .LvlWidth(LvlWidth)) u_arb (
        .valid_i (elig),
        .level_i (level_i),
        .valid_o (win_valid),
        .id_o    (win_id),
        .level_o (win_lvl)
    );

    always_comb begin
        sel_d = '{valid: win_valid, id: win_id, level: win_lvl, priv: priv_i[win_id], shv: shv_i[win_id]};
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        kill_d     = kill_q;
        id_d       = id_q;
        lvl_d      = lvl_q;
        priv_d     = priv_q;
        shv_d      = shv_q;
        claim_d    = 1'b0;
        claim_id_d = claim_id_q;
        case (state_q)
            TX_IDLE: if (sel_q.valid) begin
                state_d = TX_OFFER;
                valid_d = 1'b1;
                id_d    = sel_q.id;
                lvl_d   = sel_q.level;
                priv_d  = sel_q.priv;
                shv_d   = sel_q.shv;
            end
            TX_OFFER: if (irq_ready_i) begin
                state_d    = TX_IDLE;
                valid_d    = 1'b0;
                claim_d    = 1'b1;
                claim_id_d = id_q;
            end else if (!elig[id_q] || (sel_q.valid && sel_q.level > lvl_q)) begin
                state_d = TX_KILL;
                kill_d  = 1'b1;
            end
            TX_KILL: if (irq_ready_i || irq_kill_ack_i) begin
                state_d    = TX_IDLE;
                valid_d    = 1'b0;
                kill_d     = 1'b0;
                claim_d    = irq_ready_i;
                claim_id_d = irq_ready_i ? id_q : claim_id_q;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= TX_IDLE;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            claim_q    <= 1'b0;
            id_q       <= '0;
            lvl_q      <= '0;
            priv_q     <= '0;
            shv_q      <= 1'b0;
            claim_id_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            kill_q     <= kill_d;
            claim_q    <= claim_d;
            id_q       <= id_d;
            lvl_q      <= lvl_d;
            priv_q     <= priv_d;
            shv_q      <= shv_d;
            claim_id_q <= claim_id_d;
        end
    end

    assign irq_valid_o    = valid_q;
    assign irq_kill_req_o = kill_q;
    assign irq_id_o       = id_q;
    assign irq_level_o    = lvl_q;
    assign irq_priv_o     = priv_q;
    assign irq_shv_o      = shv_q;
    assign claim_o        = claim_q;
    assign claim_id_o     = claim_id_q;

endmodule

// File: tb/tb_clic_irq_sender.sv
// tb_clic_irq_sender: directed vectors checked against a transaction-level model every cycle.
module tb_clic_irq_sender;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] pending, enable, shv;
    logic [7:0]   level [256];
    logic [1:0]   priv  [256];
    logic [7:0]   thresh;
    logic         ready, ack;
    logic         valid, kill, claim, sh;
    logic [7:0]   id, lvl, claim_id;
    logic [1:0]   pr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clic_irq_sender dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pending_i      (pending),
        .enable_i       (enable),
        .level_i        (level),
        .priv_i         (priv),
        .shv_i          (shv),
        .thresh_i       (thresh),
        .irq_valid_o    (valid),
        .irq_ready_i    (ready),
        .irq_id_o       (id),
        .irq_level_o    (lvl),
        .irq_priv_o     (pr),
        .irq_shv_o      (sh),
        .irq_kill_req_o (kill),
        .irq_kill_ack_i (ack),
        .claim_o        (claim),
        .claim_id_o     (claim_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit eligible(input int i);
        return pending[i] && enable[i] && (level[i] > thresh);
    endfunction

    // Plain argmax over all sources; scanning upward with >= leaves the highest id on ties.
    task automatic best(output bit v, output logic [7:0] bid, output logic [7:0] bl, output logic [1:0] bp, output logic bs);
        v = 0; bid = 0; bl = 0; bp = 0; bs = 0;
        for (int i = 0; i < 256; i++) begin
            if (eligible(i) && (!v || level[i] >= bl)) begin
                v = 1; bid = 8'(i); bl = level[i]; bp = priv[i]; bs = shv[i];
            end
        end
    endtask

    bit         s_valid, m_valid, m_kill, m_claim, m_shv, s_shv;
    logic [7:0] s_id, s_lvl, m_id, m_lvl, m_claim_id;
    logic [1:0] s_priv, m_priv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid = 0; s_id = 0; s_lvl = 0; s_priv = 0; s_shv = 0;
            m_valid = 0; m_kill = 0; m_claim = 0; m_id = 0; m_lvl = 0; m_priv = 0; m_shv = 0; m_claim_id = 0;
        end else begin
            m_claim = 0;
            if (!m_valid) begin
                if (s_valid) begin
                    m_valid = 1; m_id = s_id; m_lvl = s_lvl; m_priv = s_priv; m_shv = s_shv;
                end
            end else if (ready) begin
                m_claim = 1; m_claim_id = m_id; m_valid = 0; m_kill = 0;
            end else if (m_kill) begin
                if (ack) begin
                    m_valid = 0; m_kill = 0;
                end
            end else if (!eligible(int'(m_id)) || (s_valid && s_lvl > m_lvl)) begin
                m_kill = 1;
            end
            best(s_valid, s_id, s_lvl, s_priv, s_shv);
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 32'(valid), 32'(m_valid));
        chk("m_kill", 32'(kill), 32'(m_kill));
        chk("m_claim", 32'(claim), 32'(m_claim));
        chk("m_claim_id", 32'(claim_id), 32'(m_claim_id));
        chk("m_id", 32'(id), 32'(m_id));
        chk("m_lvl", 32'(lvl), 32'(m_lvl));
        chk("m_priv", 32'(pr), 32'(m_priv));
        chk("m_shv", 32'(sh), 32'(m_shv));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seen;
        pending = '0; enable = '0; shv = '0; thresh = 0; ready = 0; ack = 0;
        for (int i = 0; i < 256; i++) begin
            level[i] = 0;
            priv[i]  = 0;
        end
        step(2);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_kill", 32'(kill), 0);
        chk("rst_claim", 32'(claim), 0);
        chk("rst_id", 32'(id), 0);
        rst = 0;
        step(1);

        pending[5] = 1; enable[5] = 1; level[5] = 3; ready = 1;
        step(1);
        chk("t1_valid_t1", 32'(valid), 0);
        step(1);
        chk("t1_valid_t2", 32'(valid), 1);
        chk("t1_id", 32'(id), 5);
        chk("t1_lvl", 32'(lvl), 3);
        pending[5] = 0;
        step(1);
        chk("t1_claim", 32'(claim), 1);
        chk("t1_claim_id", 32'(claim_id), 5);
        chk("t1_valid_low", 32'(valid), 0);
        ready = 0;
        step(3);

        pending[10] = 1; enable[10] = 1; level[10] = 7;
        pending[200] = 1; enable[200] = 1; level[200] = 7;
        step(2);
        chk("t2_valid", 32'(valid), 1);
        chk("t2_tie_id", 32'(id), 200);
        pending[201] = 1; enable[201] = 1; level[201] = 9;
        step(1);
        chk("t2_no_kill_yet", 32'(kill), 0);
        step(1);
        chk("t2_kill", 32'(kill), 1);
        chk("t2_kill_id", 32'(id), 200);
        ack = 1;
        step(1);
        chk("t2_killed_valid", 32'(valid), 0);
        chk("t2_killed_claim", 32'(claim), 0);
        ack = 0;
        step(1);
        chk("t2_reoffer_id", 32'(id), 201);
        chk("t2_reoffer_lvl", 32'(lvl), 9);
        pending = '0; ready = 1;
        step(1);
        chk("t2_claim_id", 32'(claim_id), 201);
        ready = 0;
        step(2);

        thresh = 4; pending[3] = 1; enable[3] = 1; level[3] = 4;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen |= int'(valid);
        end
        chk("t3_below_thresh", 32'(seen), 0);
        thresh = 3;
        step(2);
        chk("t3_valid", 32'(valid), 1);
        chk("t3_id", 32'(id), 3);
        pending[3] = 0; ready = 1;
        step(1);
        chk("t3_claim_id", 32'(claim_id), 3);
        ready = 0; thresh = 0;
        step(2);

        pending[7] = 1; enable[7] = 1; level[7] = 5; priv[7] = 1;
        step(2);
        chk("t4_id", 32'(id), 7);
        enable[7] = 0;
        step(1);
        chk("t4_kill", 32'(kill), 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_hold_valid", 32'(valid), 1);
            chk("t4_hold_kill", 32'(kill), 1);
            chk("t4_hold_id", 32'(id), 7);
            chk("t4_hold_priv", 32'(pr), 1);
        end
        ack = 1;
        step(1);
        chk("t4_idle_valid", 32'(valid), 0);
        chk("t4_idle_kill", 32'(kill), 0);
        chk("t4_no_claim", 32'(claim), 0);
        ack = 0; pending[7] = 0; enable[7] = 1;
        step(2);

        pending[20] = 1; enable[20] = 1; level[20] = 2;
        step(2);
        chk("t5_id", 32'(id), 20);
        enable[20] = 0;
        step(1);
        chk("t5_kill", 32'(kill), 1);
        ready = 1; ack = 1; pending[20] = 0;
        step(1);
        chk("t5_claim", 32'(claim), 1);
        chk("t5_claim_id", 32'(claim_id), 20);
        chk("t5_valid", 32'(valid), 0);
        chk("t5_kill_drop", 32'(kill), 0);
        ready = 0; ack = 0; enable[20] = 1;
        step(2);

        pending[0] = 1; enable[0] = 1; level[0] = 1; priv[0] = 2; shv[0] = 1;
        step(2);
        chk("t6_valid", 32'(valid), 1);
        chk("t6_shv", 32'(sh), 1);
        #2 rst = 1;
        #1;
        chk("t6_rst_valid", 32'(valid), 0);
        chk("t6_rst_priv", 32'(pr), 0);
        chk("t6_rst_shv", 32'(sh), 0);
        chk("t6_rst_claim", 32'(claim), 0);
        step(2);
        rst = 0;
        step(1);
        chk("t6_rel_t1", 32'(valid), 0);
        step(1);
        chk("t6_rel_t2", 32'(valid), 1);
        chk("t6_rel_id", 32'(id), 0);
        chk("t6_rel_priv", 32'(pr), 2);
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clic_irq_sender.md
# clic_irq_sender

Interrupt-source side of the CLIC-to-core interrupt interface. Arbitrates up to `NumSrc` pending, enabled sources by level and ID and presents the winner to the CVA6 CLIC port through a valid/ready handshake. Retracts an offered interrupt through a kill request/acknowledge handshake and emits a claim pulse when the core accepts it. Sits in the CLIC controller between the per-source pending/config registers and the core's `clic_irq_*` inputs.

## Interface
- `NumSrc`, 256: number of interrupt sources, must be at least 2.
- `IdWidth`, `$clog2(NumSrc)`: width of a source ID.
- `LvlWidth`, 8: width of an interrupt level.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, asynchronous and active-high.
- `pending_i`  in  NumSrc  per-source pending bits.
- `enable_i`  in  NumSrc  per-source enable bits.
- `level_i`  in  NumSrc x LvlWidth  per-source level.
- `priv_i`  in  NumSrc x 2  per-source target privilege.
- `shv_i`  in  NumSrc  per-source selective-hardware-vectoring bit.
- `thresh_i`  in  LvlWidth  minimum threshold; a source is eligible only if its level is greater than `thresh_i`.
- `irq_valid_o`  out  1  interrupt offered to the core.
- `irq_ready_i`  in  1  core accepts the offered interrupt.
- `irq_id_o`, `irq_level_o`, `irq_priv_o`, `irq_shv_o`  out  IdWidth / LvlWidth / 2 / 1  attributes of the offered interrupt.
- `irq_kill_req_o`  out  1  request to retract the offered interrupt.
- `irq_kill_ack_i`  in  1  core has retracted it.
- `claim_o`  out  1  one-cycle pulse when an interrupt is accepted.
- `claim_id_o`  out  IdWidth  ID of the accepted source, valid while `claim_o` is high.

## Operation
- Eligibility per source: `pending & enable & (level > thresh_i)`. A level-0 source is therefore never eligible.
- Arbitration is combinational:
  - highest level wins;
  - on equal levels, the highest ID wins.
- The winner's ID, level, priv and shv, plus an any-eligible flag, are registered every cycle into `sel_q`.
- FSM states and transitions:
  - **IDLE**: if `sel_q` is valid, load the output registers from `sel_q`, assert `irq_valid_o`, go to OFFER.
  - **OFFER**: outputs are held constant.
    - If `irq_ready_i` is high: pulse `claim_o` with `claim_id_o = irq_id_o`, deassert valid, go to IDLE.
    - Otherwise, if the offered source is no longer eligible (evaluated live from the inputs at `irq_id_o`), or `sel_q` holds a strictly higher level: assert `irq_kill_req_o`, go to KILL.
  - **KILL**: `irq_valid_o` and `irq_kill_req_o` stay high and the attributes stay held.
    - If `irq_ready_i` is high: the interrupt counts as taken. Pulse the claim, drop both valid and kill request, go to IDLE.
    - Else if `irq_kill_ack_i` is high: drop both valid and kill request, go to IDLE with no claim.
- `irq_ready_i` and `irq_kill_ack_i` high in the same cycle: ready wins.
- Stray `irq_kill_ack_i` in IDLE or OFFER is ignored. Stray `irq_ready_i` in IDLE is ignored.
- The block never clears pending bits itself; the register file uses the claim to clear edge-triggered sources.

## Timing
- Reset values: state IDLE, `sel_q` invalid, and every output 0.
- Reset asserted mid-offer drops all outputs asynchronously; no claim is generated.
- Latency: `pending_i` rising in cycle t (all other conditions met, state IDLE) gives `irq_valid_o` high in cycle t+2.
- Accept: `irq_ready_i` sampled high at the end of cycle n gives `claim_o` high and `irq_valid_o` low in cycle n+1.
- Back-to-back offers: after a claim or kill returns to IDLE, the next offer appears one cycle later at the earliest. That offer is taken from `sel_q`, which may still show the just-claimed source if its pending bit has not yet cleared; this is correct CLIC behaviour for level-triggered sources.
- Kill: the triggering condition seen in cycle n gives `irq_kill_req_o` high in cycle n+1.
- All outputs are driven from registers, with no combinational input-to-output path.

## Structure
- A shared `clic_pkg` holds:
  - `clic_sel_t` struct {valid, id, level, priv, shv};
  - the FSM state enum `clic_tx_state_e`.
- Sub-module `clic_arb_tree`: parameterised binary max-tree over (level, id), purely combinational, log2(NumSrc) stages. The top level instantiates it once and owns `sel_q`, the FSM and the output registers.

## Test plan
- **Single source:** src 5, level 3, thresh 0, ready tied high → valid at t+2 with id 5, level 3; claim_id 5 one cycle after the accept.
- **Tie and priority:** src 10 at level 7 and src 200 at level 7 → id 200 is offered. Then src 201 at level 9 → offer of 200 is killed; after kill_ack, id 201 is offered.
- **Threshold:** src 3 at level 4 with thresh 4 → no valid for 20 cycles. Set thresh to 3 → valid at id 3 within 2 cycles.
- **Retraction:** offer id 7, then drop `enable_i[7]` with ready low → kill_req next cycle. Delay kill_ack 5 cycles: outputs stay stable throughout, then return to idle with no claim.
- **Ready/ack collision:** in KILL, assert `irq_ready_i` and `irq_kill_ack_i` in the same cycle → claim pulse with the held id; valid and kill_req drop together.
- **Reset mid-offer:** assert `rst_i` while valid is high → all outputs 0 immediately. Release with src 0 at level 1 still pending → valid two cycles after the reset-release edge.
